// File: rtl/cordic_result_fp_pipe.sv
// Three-stage valid/ready converter from signed fixed-point (CORDIC x) to IEEE-754 single.
// Optional unit clamp of |value| > 1.0 is enabled by defining CORDIC_FP_CLAMP_UNIT_EN.
module cordic_result_fp_pipe #(
  parameter int WIDTH     = 21,
  parameter int FRAC_BITS = 19
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clk_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data
);

  localparam int PW = $clog2(WIDTH);

  logic             w_adv;
  logic [WIDTH-1:0] w_s1_mag;
  logic [PW-1:0]    w_lead_pos;
  logic [4:0]       w_shamt;
  logic [7:0]       w_exp;
  logic [22:0]      w_frac;
  logic [31:0]      w_result;

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [WIDTH-1:0] r_s1_mag;

  logic             r_s2_valid;
  logic             r_s2_sign;
  logic [WIDTH-1:0] r_s2_mag;
  logic [PW-1:0]    r_s2_pos;
  logic             r_s2_zero;

  logic             r_s3_valid;
  logic [31:0]      r_s3_data;

  // Global stall: every stage moves together, so bubbles are kept in place.
  assign w_adv    = clk_en && (!r_s3_valid || out_ready);
  assign in_ready = w_adv && !aclr;

  // Most-negative input wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign w_s1_mag = in_data[WIDTH-1] ? -in_data : in_data;

  always_comb begin
    w_lead_pos = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_s1_mag[i]) w_lead_pos = PW'(i);
    end
  end

  assign w_shamt = 5'd23 - 5'(r_s2_pos);
  assign w_frac  = 23'(24'(r_s2_mag) << w_shamt);
  assign w_exp   = 8'(127 + int'(r_s2_pos) - FRAC_BITS);

`ifdef CORDIC_FP_CLAMP_UNIT_EN
  localparam logic [24:0] UNIT = 25'(1) << FRAC_BITS;
  logic w_over_unit;
  assign w_over_unit = 25'(r_s2_mag) > UNIT;
`endif

  always_comb begin
    w_result = {r_s2_sign, w_exp, w_frac};
`ifdef CORDIC_FP_CLAMP_UNIT_EN
    if (w_over_unit) w_result = {r_s2_sign, 31'h3F80_0000};
`endif
    if (r_s2_zero) w_result = '0;
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s3_data  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
      if (in_valid) begin
        r_s1_sign <= in_data[WIDTH-1];
        r_s1_mag  <= w_s1_mag;
      end
      if (r_s1_valid) begin
        r_s2_sign <= r_s1_sign;
        r_s2_mag  <= r_s1_mag;
        r_s2_pos  <= w_lead_pos;
        r_s2_zero <= (r_s1_mag == '0);
      end
      if (r_s2_valid) r_s3_data <= w_result;
    end
  end

  assign out_valid = r_s3_valid;
  assign out_data  = r_s3_data;

endmodule
